// File: rtl/des_pkg.sv
// -----------------------------------------------------------------------------
// des_pkg
// Shared DES constants and helpers for the bridge's DES engines:
//   - FSM state enum of the iterative decryption core
//   - IP, FP, E, P, PC1 and PC2 index tables (1-based DES bit numbers)
//   - S-box contents, flattened as row*16 + column
//   - per-round right-rotation schedule of the reverse key schedule
//   - permutation, S-box, rotation and key-parity helper functions
// All vectors use DES numbering: index 0 is DES bit 1, the MSB.
// -----------------------------------------------------------------------------
package des_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } des_state_e;

    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10,  2, 60, 52, 44, 36, 28, 20, 12,  4,
        62, 54, 46, 38, 30, 22, 14,  6, 64, 56, 48, 40, 32, 24, 16,  8,
        57, 49, 41, 33, 25, 17,  9,  1, 59, 51, 43, 35, 27, 19, 11,  3,
        61, 53, 45, 37, 29, 21, 13,  5, 63, 55, 47, 39, 31, 23, 15,  7
    };

    localparam int FP_T [64] = '{
        40,  8, 48, 16, 56, 24, 64, 32, 39,  7, 47, 15, 55, 23, 63, 31,
        38,  6, 46, 14, 54, 22, 62, 30, 37,  5, 45, 13, 53, 21, 61, 29,
        36,  4, 44, 12, 52, 20, 60, 28, 35,  3, 43, 11, 51, 19, 59, 27,
        34,  2, 42, 10, 50, 18, 58, 26, 33,  1, 41,  9, 49, 17, 57, 25
    };

    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1
    };

    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
    };

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    localparam int SBOX [8][64] = '{
        '{14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
           0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
           4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
          15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13},
        '{15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
           3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
           0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
          13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9},
        '{10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
          13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
          13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
           1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12},
        '{ 7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
          13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
          10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
           3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14},
        '{ 2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
          14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
           4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
          11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3},
        '{12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
          10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
           9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
           4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13},
        '{ 4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
          13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
           1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
           6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12},
        '{13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
           1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
           7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
           2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11}
    };

    // Rounds (counter index, left to right) whose C/D rotation is one place;
    // all others rotate by two. This undoes the forward left-shift schedule
    // walked backwards from C16D16.
    localparam logic [0:15] ROT1_MASK = 16'b1000_0001_0000_0010;

    function automatic logic [0:63] des_ip(input logic [0:63] x);
        logic [0:63] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[6'(i)] = x[6'(IP_T[i] - 1)];
        return y;
    endfunction

    function automatic logic [0:63] des_fp(input logic [0:63] x);
        logic [0:63] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[6'(i)] = x[6'(FP_T[i] - 1)];
        return y;
    endfunction

    function automatic logic [0:47] des_e(input logic [0:31] x);
        logic [0:47] y;
        y = '0;
        for (int i = 0; i < 48; i++) y[6'(i)] = x[5'(E_T[i] - 1)];
        return y;
    endfunction

    function automatic logic [0:31] des_p(input logic [0:31] x);
        logic [0:31] y;
        y = '0;
        for (int i = 0; i < 32; i++) y[5'(i)] = x[5'(P_T[i] - 1)];
        return y;
    endfunction

    function automatic logic [0:55] des_pc1(input logic [0:63] x);
        logic [0:55] y;
        y = '0;
        for (int i = 0; i < 56; i++) y[6'(i)] = x[6'(PC1_T[i] - 1)];
        return y;
    endfunction

    function automatic logic [0:47] des_pc2(input logic [0:55] x);
        logic [0:47] y;
        y = '0;
        for (int i = 0; i < 48; i++) y[6'(i)] = x[6'(PC2_T[i] - 1)];
        return y;
    endfunction

    // Outer bits (first, last) select the row, inner four the column.
    function automatic logic [3:0] sbox_lookup(input int box, input logic [0:5] six);
        logic [5:0] idx;
        idx = {six[0], six[5], six[1:4]};
        return 4'(SBOX[box][idx]);
    endfunction

    function automatic logic [0:27] ror28(input logic [0:27] x, input logic by_one);
        return by_one ? {x[27], x[0:26]} : {x[26:27], x[0:25]};
    endfunction

    // A key byte is good when it holds an odd number of ones.
    function automatic logic key_parity_bad(input logic [0:63] k);
        logic bad;
        bad = 1'b0;
        for (int b = 0; b < 8; b++) bad = bad | ~(^k[b*8 +: 8]);
        return bad;
    endfunction

endpackage

// File: rtl/des_decrypt_core_round_f.sv
// -----------------------------------------------------------------------------
// des_round_f
// Combinational DES round function f(R, K) = P(S(E(R) ^ K)). Shared with the
// encrypting codec, so it carries no clock and no key-order knowledge.
// Ports:
//   r  in  [0:31]  right half of the Feistel state
//   k  in  [0:47]  round subkey
//   f  out [0:31]  round function output
// -----------------------------------------------------------------------------
module des_round_f
    import des_pkg::*;
(
    input  logic [0:31] r,
    input  logic [0:47] k,
    output logic [0:31] f
);

    logic [0:47] x;
    logic [0:31] s_out;

    always_comb begin
        x     = des_e(r) ^ k;
        s_out = '0;
        for (int s = 0; s < 8; s++) begin
            s_out[s*4 +: 4] = sbox_lookup(s, x[s*6 +: 6]);
        end
        f = des_p(s_out);
    end

endmodule

// File: rtl/des_decrypt_core.sv
// -----------------------------------------------------------------------------
// des_decrypt_core
// Iterative single-DES decryption: one block accepted, 16 rounds at one per
// clock with subkeys K16..K1 produced by rotating C/D right, result held
// until the consumer takes it.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   in_valid/ready  input handshake; in_data = ciphertext, in_key = 64-bit key
//   out_valid/ready output handshake; out_data = plaintext
//   key_parity_err  odd-parity failure of the accepted key (CHECK_PARITY=1)
//   busy            block in flight or awaiting output handshake
// -----------------------------------------------------------------------------
module des_decrypt_core
    import des_pkg::*;
#(
    parameter bit CHECK_PARITY = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [0:63] in_data,
    input  logic [0:63] in_key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [0:63] out_data,
    output logic        key_parity_err,
    output logic        busy
);

    des_state_e  state_q, state_d;
    logic [0:31] l_q, l_d, r_q, r_d;
    logic [0:27] c_q, c_d, d_q, d_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        perr_q, perr_d;

    logic [0:47] subkey;
    logic [0:31] f_val;
    logic        accept;

    assign accept = in_valid && (state_q == IDLE);
    assign subkey = des_pc2({c_q, d_q});

    des_round_f u_round_f (
        .r (r_q),
        .k (subkey),
        .f (f_val)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            l_q     <= '0;
            r_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            l_q     <= l_d;
            r_q     <= r_d;
            c_q     <= c_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            perr_q  <= perr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid) state_d = ROUND;
            ROUND:   if (cnt_q == 4'd15) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        l_d    = l_q;
        r_d    = r_q;
        c_d    = c_q;
        d_d    = d_q;
        cnt_d  = cnt_q;
        perr_d = perr_q;
        if (accept) begin
            {l_d, r_d} = des_ip(in_data);
            // C16D16 equals C0D0, so the first decryption subkey (K16)
            // comes straight from PC1 with no rotation.
            {c_d, d_d} = des_pc1(in_key);
            cnt_d      = '0;
            perr_d     = CHECK_PARITY && key_parity_bad(in_key);
        end else if (state_q == ROUND) begin
            l_d   = r_q;
            r_d   = l_q ^ f_val;
            c_d   = ror28(c_q, ROT1_MASK[cnt_q]);
            d_d   = ror28(d_q, ROT1_MASK[cnt_q]);
            // Saturate so the counter never wraps even if held in ROUND.
            cnt_d = (cnt_q == 4'd15) ? cnt_q : cnt_q + 4'd1;
        end
    end

    always_comb begin
        // in_ready is forced low while reset is held even though the
        // state register already reads IDLE.
        in_ready       = rst_n && (state_q == IDLE);
        out_valid      = (state_q == DONE);
        busy           = (state_q == ROUND) || (state_q == DONE);
        out_data       = '0;
        key_parity_err = 1'b0;
        if (state_q == DONE) begin
            // Final swap undone: preoutput is R16 followed by L16.
            out_data       = des_fp({r_q, l_q});
            key_parity_err = perr_q;
        end
    end

endmodule

// File: tb/tb_des_decrypt_core.sv
// -----------------------------------------------------------------------------
// tb_des_decrypt_core
// Directed bench for des_decrypt_core (CHECK_PARITY=1) using published DES
// known-answer vectors.
// -----------------------------------------------------------------------------
module tb_des_decrypt_core;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [0:63] in_data;
    logic [0:63] in_key;
    logic        out_valid;
    logic        out_ready;
    logic [0:63] out_data;
    logic        key_parity_err;
    logic        busy;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int acc_cyc = 0;
    int prev_acc = 0;

    des_decrypt_core #(.CHECK_PARITY(1'b1)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .in_key         (in_key),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .key_parity_err (key_parity_err),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a block and wait (bounded) for it to be taken; returns after
    // the acceptance edge with in_valid dropped.
    task automatic accept_block(input string tag, input logic [0:63] d, input logic [0:63] k);
        int n;
        n        = 0;
        in_data  = d;
        in_key   = k;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_accept_timeout"}, 64'(n < 50), 64'd1);
        tick();
        prev_acc = acc_cyc;
        acc_cyc  = cyc;
        in_valid = 1'b0;
    endtask

    // Walk edges T+1..T+16 and check the result in DONE. With scramble set,
    // in_valid stays high with fresh data/key during the rounds.
    task automatic wait_done(input string tag, input logic [0:63] exp_pt,
                             input logic exp_perr, input bit scramble);
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (scramble) begin
                in_valid = (k < 15);
                in_data  = {$urandom, $urandom};
                in_key   = {$urandom, $urandom};
            end
            if (k == 8) begin
                check({tag, "_busy_mid"}, 64'(busy), 64'd1);
                check({tag, "_in_ready_mid"}, 64'(in_ready), 64'd0);
            end
            if (k == 15) check({tag, "_valid_early"}, 64'(out_valid), 64'd0);
        end
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_data"}, out_data, exp_pt);
        check({tag, "_perr"}, 64'(key_parity_err), 64'(exp_perr));
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_in_ready_after"}, 64'(in_ready), 64'd1);
        check({tag, "_valid_after"}, 64'(out_valid), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_out_data"}, out_data, 64'd0);
        check({tag, "_perr"}, 64'(key_parity_err), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_key    = '0;
        out_ready = 1'b0;

        // Reset state
        tick();
        tick();
        check_reset_outputs("rst");
        rst_n = 1'b1;
        #1;
        check("rst_release_in_ready", 64'(in_ready), 64'd1);

        // Basic decrypt
        out_ready = 1'b1;
        accept_block("basic", 64'h85E813540F0AB405, 64'h133457799BBCDFF1);
        out_ready = 1'b0;
        check("basic_busy_accept", 64'(busy), 64'd1);
        wait_done("basic", 64'h0123456789ABCDEF, 1'b0, 1'b0);
        handshake("basic");

        // Zero key with parity error, then backpressure
        accept_block("zero", 64'h8CA64DE9C1B123A7, 64'h0000000000000000);
        wait_done("zero", 64'h0000000000000000, 1'b1, 1'b0);
        in_valid = 1'b1;
        in_data  = 64'hDEADBEEFCAFEF00D;
        for (int c = 0; c < 10; c++) begin
            tick();
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_data", out_data, 64'h0000000000000000);
            check("bp_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        handshake("bp");

        // Input stability: inputs churn while rounds run
        accept_block("stab", 64'h0000000000000000, 64'h0E329232EA6D0D73);
        wait_done("stab", 64'h8787878787878787, 1'b0, 1'b1);
        handshake("stab");

        // Reset mid-operation at round 8
        accept_block("mrst", 64'h3FA40E8A984D4815, 64'h0123456789ABCDEF);
        for (int c = 0; c < 8; c++) tick();
        check("mrst_busy_pre", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mrst");
        tick();
        rst_n = 1'b1;
        #1;
        check("mrst_release_in_ready", 64'(in_ready), 64'd1);
        accept_block("mrst2", 64'h3FA40E8A984D4815, 64'h0123456789ABCDEF);
        wait_done("mrst2", 64'h4E6F772069732074, 1'b0, 1'b0);
        handshake("mrst2");

        // Back-to-back with the consumer always ready
        out_ready = 1'b1;
        accept_block("b2b0", 64'h8000000000000000, 64'h0101010101010101);
        wait_done("b2b0", 64'h95F8A5E5DD31D900, 1'b0, 1'b0);
        accept_block("b2b1", 64'h4000000000000000, 64'h0101010101010101);
        check("b2b1_gap", 64'((acc_cyc - prev_acc) >= 18), 64'd1);
        wait_done("b2b1", 64'hDD7F121CA5015619, 1'b0, 1'b0);
        accept_block("b2b2", 64'h7359B2163E4EDC58, 64'hFFFFFFFFFFFFFFFF);
        check("b2b2_gap", 64'((acc_cyc - prev_acc) >= 18), 64'd1);
        wait_done("b2b2", 64'hFFFFFFFFFFFFFFFF, 1'b1, 1'b0);
        tick();
        out_ready = 1'b0;
        check("b2b_idle_in_ready", 64'(in_ready), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
